// File: rtl/exec_pkg.sv
// Shared types and defaults for the execute/writeback stage.
// The EXEC_MUL_EN macro enables the iterative multiplier path.
package exec_pkg;

    localparam int EXEC_DW = 8;
    localparam int EXEC_AW = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } exec_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } exec_state_e;

endpackage

// File: rtl/exec_stage_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, W cycles per operation.
// Built only when EXEC_MUL_EN is defined.
module mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;

    // The product is valid combinationally during the final step
    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o = busy_q && (cnt_q == CW'(W - 1));
    assign busy_o = busy_q;
    assign prod_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage with writeback forwarding into reg_file.
// Define EXEC_MUL_EN to support MUL; otherwise opcode 7 raises err.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DW = EXEC_DW,
    parameter int AW = EXEC_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    output logic [AW-1:0] rf_rd_addr1,
    output logic [AW-1:0] rf_rd_addr2,
    input  logic [DW-1:0] rf_rd_data1,
    input  logic [DW-1:0] rf_rd_data2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          err
);

    exec_op_e      op;
    logic          fire;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] res;
    logic [DW:0]   sum;
    logic          carry;

    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          z_q;
    logic          c_q;
    logic          err_q;

    assign op          = exec_op_e'(in_op);
    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;

    // The pending writeback has not reached the register file yet
    assign opa = (we_q && waddr_q == in_rs1) ? wdata_q : rf_rd_data1;
    assign opb = (we_q && waddr_q == in_rs2) ? wdata_q : rf_rd_data2;

    always_comb begin
        res   = '0;
        sum   = '0;
        carry = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum   = {1'b0, opa} + {1'b0, opb};
                res   = sum[DW-1:0];
                carry = sum[DW];
            end
            OP_SUB: begin
                sum   = {1'b0, opa} - {1'b0, opb};
                res   = sum[DW-1:0];
                carry = sum[DW];
            end
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_XOR: res = opa ^ opb;
            OP_SHL: res = opa << opb[2:0];
            OP_SHR: res = opa >> opb[2:0];
            OP_MUL: res = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    exec_state_e     state_q;
    logic [AW-1:0]   rd_q;
    logic            mul_busy;
    logic            mul_done;
    logic [2*DW-1:0] mul_prod;

    assign in_ready = !rst && state_q == S_IDLE && !mul_busy;
    assign fire     = in_valid && in_ready;

    mul_iter #(.W(DW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (fire && op == OP_MUL),
        .a_i     (opa),
        .b_i     (opb),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fire && op == OP_MUL) begin
                        state_q <= S_MUL;
                        rd_q    <= in_rd;
                    end else if (fire) begin
                        we_q    <= 1'b1;
                        waddr_q <= in_rd;
                        wdata_q <= res;
                        z_q     <= (res == '0);
                        c_q     <= carry;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b1;
                        waddr_q <= rd_q;
                        wdata_q <= mul_prod[DW-1:0];
                        z_q     <= (mul_prod[DW-1:0] == '0);
                        c_q     <= |mul_prod[2*DW-1:DW];
                    end
                end
            endcase
        end
    end
`else
    assign in_ready = !rst;
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= fire && op == OP_MUL;
            if (fire && op != OP_MUL) begin
                we_q    <= 1'b1;
                waddr_q <= in_rd;
                wdata_q <= res;
                z_q     <= (res == '0);
                c_q     <= carry;
            end
        end
    end
`endif

    assign rf_we      = we_q;
    assign rf_wr_addr = waddr_q;
    assign rf_wr_data = wdata_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign err        = err_q;

endmodule
